sys_run_ctrl: RTL and testbench

Run/step/breakpoint controller for the MIPS core inside `system`. It turns the board clock into a CPU clock-enable (`cpu_ce`) at a rate of one pulse per `DIVISOR` clocks. It sequences the core through RUN, HALT and single-STEP modes under button/switch requests, and halts the core automatically when the fetched PC matches a breakpoint address. It sits between the board inputs and the core's enable pin, and drives `CLK_led`.

---
 rtl/sys_ctrl_pkg.sv | 24 ++
 rtl/sys_prescaler.sv | 38 +++
 rtl/sys_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sys_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_ctrl_pkg
// Shared types and widths for the run/step/breakpoint controller.
//   run_state_t : controller mode (RUN, HALT, STEP)
//   PC_W        : width of the core program counter / breakpoint address
//   CNT_W       : width of the cpu_ce pulse counter
//   rise()      : rising-edge test on a registered sample and its predecessor
// -----------------------------------------------------------------------------
package sys_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } run_state_t;

    localparam int PC_W  = 8;
    localparam int CNT_W = 32;

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/sys_prescaler.sv
// -----------------------------------------------------------------------------
// sys_prescaler
// Free-running modulo-DIVISOR counter that flags the last count of each period.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear to 0 (wins over enable)
//   enable : advance the counter
//   tick   : high while enabled and the counter sits at DIVISOR-1
// -----------------------------------------------------------------------------
module sys_prescaler #(
    parameter int unsigned DIVISOR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // With DIVISOR = 1 the counter never leaves 0, so tick is continuous.
    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/sys_run_ctrl.sv
// -----------------------------------------------------------------------------
// sys_run_ctrl
// Run/step/breakpoint controller for the MIPS core. Produces a one-cycle core
// clock enable every DIVISOR clocks in RUN, single pulses in STEP, and stops
// the core when the fetched PC matches the breakpoint address.
//
// Optional build macro: SYS_RUN_CTRL_CYCLE_CNT_EN
//   defined   -> 32-bit cpu_ce pulse counter on cycle_cnt
//   undefined -> cycle_cnt tied to 0, no counter flops
//
// Ports:
//   SYS_clk, SYS_reset_n         : clock and asynchronous active-low reset
//   run_req, halt_req, step_req  : level requests, acted on at their rising edge
//   bp_en, bp_addr               : breakpoint enable and PC byte address
//   PC                           : current core PC
//   cpu_ce                       : core clock enable, one cycle wide
//   CLK_led                      : toggles on every cpu_ce
//   halted                       : 1 while in HALT
//   brk_hit                      : sticky breakpoint-stop flag
//   cycle_cnt                    : number of cpu_ce pulses issued
// -----------------------------------------------------------------------------
module sys_run_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DIVISOR      = 1,
    parameter bit          RUN_ON_RESET = 1'b1
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  PC,
    output logic             cpu_ce,
    output logic             CLK_led,
    output logic             halted,
    output logic             brk_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam run_state_t RESET_STATE = RUN_ON_RESET ? RUN : HALT;

    run_state_t state;
    logic       run_p0, run_p1, halt_p0, halt_p1, step_p0, step_p1;
    logic       run_edge, halt_edge, step_edge;
    logic       skip;
    logic       tick, prescale_en, prescale_clr;
    logic       bp_hit, ce_next;

    assign run_edge  = rise(run_p0, run_p1);
    assign halt_edge = rise(halt_p0, halt_p1);
    assign step_edge = rise(step_p0, step_p1);

    // Prescaler only runs in RUN; a halt edge drops a pending tick.
    assign prescale_en  = (state == RUN);
    assign prescale_clr = (state != RUN) || halt_edge;

    sys_prescaler #(
        .DIVISOR (DIVISOR)
    ) u_prescaler (
        .clk    (SYS_clk),
        .rst_n  (SYS_reset_n),
        .clear  (prescale_clr),
        .enable (prescale_en),
        .tick   (tick)
    );

    // Skip lets a resumed RUN execute the instruction sitting at bp_addr once.
    assign bp_hit = bp_en && (PC == bp_addr) && !skip;

    // A pulse is issued by a clean RUN tick or by a step edge taken from HALT.
    assign ce_next = ((state == RUN)  && !halt_edge && tick && !bp_hit) ||
                     ((state == HALT) && !halt_edge && step_edge);

    // Stage p0: request sample, p1: previous sample; edges feed the FSM.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            run_p0  <= 1'b0;
            run_p1  <= 1'b0;
            halt_p0 <= 1'b0;
            halt_p1 <= 1'b0;
            step_p0 <= 1'b0;
            step_p1 <= 1'b0;
            state   <= RESET_STATE;
            halted  <= !RUN_ON_RESET;
            cpu_ce  <= 1'b0;
            CLK_led <= 1'b0;
            brk_hit <= 1'b0;
            skip    <= 1'b0;
        end else begin
            run_p0  <= run_req;
            run_p1  <= run_p0;
            halt_p0 <= halt_req;
            halt_p1 <= halt_p0;
            step_p0 <= step_req;
            step_p1 <= step_p0;

            cpu_ce <= ce_next;
            if (ce_next) begin
                CLK_led <= ~CLK_led;
                skip    <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (halt_edge) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (tick && bp_hit) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        brk_hit <= 1'b1;
                    end
                end
                HALT: begin
                    // Halt edge outranks step and run; losers are discarded.
                    if (!halt_edge) begin
                        if (step_edge) begin
                            state   <= STEP;
                            halted  <= 1'b0;
                            brk_hit <= 1'b0;
                        end else if (run_edge) begin
                            state   <= RUN;
                            halted  <= 1'b0;
                            brk_hit <= 1'b0;
                            skip    <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef SYS_RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            cnt_q <= '0;
        end else if (ce_next) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_run_ctrl
// Bench for sys_run_ctrl (DIVISOR = 4, RUN_ON_RESET = 1). A reference model
// predicts the outputs after every clock and queues them; a monitor pops and
// compares on the following falling edge. Directed sequences follow the
// controller's documented scenarios, then randomized requests run against
// the model. A small core stand-in advances PC by 4 on every cpu_ce.
// -----------------------------------------------------------------------------
module tb_sys_run_ctrl;

    localparam int unsigned DIV = 4;

`ifdef SYS_RUN_CTRL_CYCLE_CNT_EN
    localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CNT_MASK = 32'h0000_0000;
`endif

    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_req, halt_req, step_req, bp_en;
    logic [7:0]  bp_addr, pc;
    logic        cpu_ce, clk_led, halted, brk_hit;
    logic [31:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    sys_run_ctrl #(
        .DIVISOR      (DIV),
        .RUN_ON_RESET (1'b1)
    ) dut (
        .SYS_clk     (clk),
        .SYS_reset_n (rst_n),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .PC          (pc),
        .cpu_ce      (cpu_ce),
        .CLK_led     (clk_led),
        .halted      (halted),
        .brk_hit     (brk_hit),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ce;
        logic        halted;
        logic        brk;
        logic        led;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          m_mode;
    int unsigned m_since;     // clocks spent in RUN since it was entered
    bit          m_skip, m_brk, m_led;
    int unsigned m_pulses;
    bit          r1, r2, h1, h2, s1, s2;  // request inputs seen at the last two clocks

    always @(posedge clk or negedge rst_n) begin : model
        bit he, se, re, pulse;
        if (!rst_n) begin
            m_mode   = M_RUN;
            m_since  = 0;
            m_skip   = 0;
            m_brk    = 0;
            m_led    = 0;
            m_pulses = 0;
            r1 = 0; r2 = 0; h1 = 0; h2 = 0; s1 = 0; s2 = 0;
            sbq.delete();
        end else begin
            he = h1 && !h2;
            se = s1 && !s2;
            re = r1 && !r2;
            pulse = 0;
            case (m_mode)
                M_RUN: begin
                    m_since++;
                    if (he) begin
                        m_mode = M_HALT;
                    end else if (m_since % DIV == 0) begin
                        if (bp_en && pc == bp_addr && !m_skip) begin
                            m_mode = M_HALT;
                            m_brk  = 1;
                        end else begin
                            pulse = 1;
                        end
                    end
                end
                M_HALT: begin
                    if (!he) begin
                        if (se) begin
                            m_mode = M_STEP;
                            m_brk  = 0;
                            pulse  = 1;
                        end else if (re) begin
                            m_mode  = M_RUN;
                            m_since = 0;
                            m_skip  = 1;
                            m_brk   = 0;
                        end
                    end
                end
                default: m_mode = M_HALT;
            endcase
            if (pulse) begin
                m_pulses++;
                m_led  = !m_led;
                m_skip = 0;
            end
            r2 = r1; r1 = run_req;
            h2 = h1; h1 = halt_req;
            s2 = s1; s1 = step_req;
            sbq.push_back('{pulse, (m_mode == M_HALT), m_brk, m_led, m_pulses & CNT_MASK});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_cpu_ce",    cpu_ce,    e.ce);
            check("sb_halted",    halted,    e.halted);
            check("sb_brk_hit",   brk_hit,   e.brk);
            check("sb_CLK_led",   clk_led,   e.led);
            check("sb_cycle_cnt", cycle_cnt, e.cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one clock; the core stand-in fetches the next word on cpu_ce.
    task automatic tick_clk();
        @(negedge clk);
        #1;
        if (cpu_ce === 1'b1) pc = pc + 8'd4;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        run_req = 0; halt_req = 0; step_req = 0;
        repeat (2) tick_clk();
        pc = 8'h00;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run_req = 0; halt_req = 0; step_req = 0;
        bp_en = 0; bp_addr = 8'h00; pc = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_ce",    cpu_ce,    32'd0);
        check("rst_CLK_led",   clk_led,   32'd0);
        check("rst_halted",    halted,    32'd0);
        check("rst_brk_hit",   brk_hit,   32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);

        // RUN out of reset: pulses at clocks 4, 8, 12
        rst_n = 1'b1;
        repeat (4) tick_clk();
        check("ce_clk4",  cpu_ce,  32'd1);
        check("led_clk4", clk_led, 32'd1);
        repeat (4) tick_clk();
        check("ce_clk8",  cpu_ce,  32'd1);
        check("led_clk8", clk_led, 32'd0);
        repeat (4) tick_clk();
        check("ce_clk12",  cpu_ce,    32'd1);
        check("led_clk12", clk_led,   32'd1);
        check("cnt_clk12", cycle_cnt, 32'd3 & CNT_MASK);

        // Halt edge sampled at clock 6
        apply_reset();
        repeat (5) tick_clk();
        halt_req = 1;
        tick_clk();
        check("halted_clk6", halted, 32'd0);
        tick_clk();
        check("halted_clk7", halted, 32'd1);
        tick_clk();
        check("no_ce_clk8", cpu_ce,    32'd0);
        check("cnt_frozen", cycle_cnt, 32'd1 & CNT_MASK);
        halt_req = 0;

        // Three single steps from HALT, 5 clocks apart
        for (int i = 0; i < 3; i++) begin
            step_req = 1;
            tick_clk();
            check("step_pre_ce", cpu_ce, 32'd0);
            step_req = 0;
            tick_clk();
            check("step_ce",     cpu_ce, 32'd1);
            check("step_halted", halted, 32'd0);
            tick_clk();
            check("step_post_ce",     cpu_ce, 32'd0);
            check("step_post_halted", halted, 32'd1);
            repeat (2) tick_clk();
        end
        check("cnt_after_steps", cycle_cnt, 32'd4 & CNT_MASK);

        // Breakpoint at 0x10, then resume past it
        bp_en = 1; bp_addr = 8'h10;
        apply_reset();
        repeat (20) tick_clk();
        check("bp_halted", halted,  32'd1);
        check("bp_brk",    brk_hit, 32'd1);
        check("bp_ce",     cpu_ce,  32'd0);
        check("bp_pc",     pc,      32'h10);
        run_req = 1;
        tick_clk();
        run_req = 0;
        tick_clk();
        check("resume_brk",    brk_hit, 32'd0);
        check("resume_halted", halted,  32'd0);
        repeat (4) tick_clk();
        check("resume_ce_at_bp", cpu_ce, 32'd1);
        check("pc_past_bp",      pc,     32'h14);
        bp_en = 0;

        // Halt + step together in RUN -> HALT, no pulse
        halt_req = 1; step_req = 1;
        tick_clk();
        halt_req = 0; step_req = 0;
        tick_clk();
        check("hs_halted", halted, 32'd1);
        check("hs_ce",     cpu_ce, 32'd0);
        // Run + step together in HALT -> one STEP pulse, then HALT
        run_req = 1; step_req = 1;
        tick_clk();
        run_req = 0; step_req = 0;
        tick_clk();
        check("rs_ce",     cpu_ce, 32'd1);
        check("rs_halted", halted, 32'd0);
        tick_clk();
        check("rs_post_ce",     cpu_ce, 32'd0);
        check("rs_post_halted", halted, 32'd1);

        // Asynchronous reset mid-RUN with the prescaler at 2
        apply_reset();
        repeat (6) tick_clk();
        check("pre_rst_led", clk_led, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cpu_ce",    cpu_ce,    32'd0);
        check("arst_CLK_led",   clk_led,   32'd0);
        check("arst_halted",    halted,    32'd0);
        check("arst_brk_hit",   brk_hit,   32'd0);
        check("arst_cycle_cnt", cycle_cnt, 32'd0);

        // Randomized requests against the model
        apply_reset();
        bp_en = 1; bp_addr = 8'h20;
        for (int c = 0; c < 3000; c++) begin
            tick_clk();
            if ($urandom_range(0, 7) == 0)  run_req  = ~run_req;
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 7) == 0)  step_req = ~step_req;
            if ($urandom_range(0, 199) == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = 8'($urandom_range(0, 63) * 4);
            end
            if (c == 1500) begin
                rst_n = 1'b0;
                tick_clk();
                rst_n = 1'b1;
            end
        end
        run_req = 0; halt_req = 0; step_req = 0;
        repeat (3) tick_clk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
